// File: rtl/video_sync_normaliser.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_normaliser
//  Description : Detects hsync/vsync polarity, re-times sync/blank/RGB by one
//                pixel enable and emits active-low HS/VS/CS with blanked RGB.
//  Revision    : 1.0  initial release
// ============================================================================
module video_sync_normaliser #(
    parameter int HCNT_W = 12,
    parameter int VCNT_W = 11
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pixel_ena,
    input  logic       csync_en,
    input  logic       hb_in,
    input  logic       vb_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    output logic       hs_out,
    output logic       vs_out,
    output logic       cs_out,
    output logic       hb_out,
    output logic       vb_out,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out,
    output logic       hs_pol,
    output logic       vs_pol,
    output logic       locked
);

    localparam logic [HCNT_W-1:0] H_MAX = '1;
    localparam logic [HCNT_W-1:0] H_ONE = 1;
    localparam logic [VCNT_W-1:0] V_MAX = '1;
    localparam logic [VCNT_W-1:0] V_ONE = 1;

    logic              hsd_q, vsd_q;
    logic [HCNT_W-1:0] h_hi_q, h_hi_d, h_lo_q, h_lo_d;
    logic [VCNT_W-1:0] v_hi_q, v_hi_d, v_lo_q, v_lo_d;
    logic              hs_pol_q, hs_pol_d, hs_lock_q, hs_lock_d;
    logic              vs_pol_q, vs_pol_d, vs_lock_q, vs_lock_d;
    logic              h_new, v_new, locked_q;
    logic              hs_rise, vs_rise, hs_act, vs_act;

    logic              hs_out_q, vs_out_q, cs_out_q, hb_out_q, vb_out_q;
    logic [5:0]        r_out_q, g_out_q, b_out_q;

    assign hs_rise = ~hsd_q & hs_in;
    assign vs_rise = ~vsd_q & vs_in;

    // A short high phase relative to the low phase means the sync is active high.
    always_comb begin
        h_hi_d    = h_hi_q;
        h_lo_d    = h_lo_q;
        hs_pol_d  = hs_pol_q;
        hs_lock_d = hs_lock_q;
        h_new     = hs_pol_q;
        if (h_hi_q < h_lo_q)
            h_new = 1'b1;
        else if (h_hi_q > h_lo_q)
            h_new = 1'b0;
        if (hs_rise) begin
            hs_lock_d = (h_new == hs_pol_q);
            hs_pol_d  = h_new;
            h_hi_d    = '0;
            h_lo_d    = '0;
        end else begin
            if (hsd_q) begin
                if (h_hi_q != H_MAX) h_hi_d = h_hi_q + H_ONE;
            end else begin
                if (h_lo_q != H_MAX) h_lo_d = h_lo_q + H_ONE;
            end
            if (h_hi_q == H_MAX && h_lo_q == H_MAX) hs_lock_d = 1'b0;
        end
    end

    // Vertical measurement counts lines (raw hsync rising edges), not clocks.
    always_comb begin
        v_hi_d    = v_hi_q;
        v_lo_d    = v_lo_q;
        vs_pol_d  = vs_pol_q;
        vs_lock_d = vs_lock_q;
        v_new     = vs_pol_q;
        if (v_hi_q < v_lo_q)
            v_new = 1'b1;
        else if (v_hi_q > v_lo_q)
            v_new = 1'b0;
        if (vs_rise) begin
            vs_lock_d = (v_new == vs_pol_q);
            vs_pol_d  = v_new;
            v_hi_d    = '0;
            v_lo_d    = '0;
        end else begin
            if (hs_rise) begin
                if (vsd_q) begin
                    if (v_hi_q != V_MAX) v_hi_d = v_hi_q + V_ONE;
                end else begin
                    if (v_lo_q != V_MAX) v_lo_d = v_lo_q + V_ONE;
                end
            end
            if (v_hi_q == V_MAX && v_lo_q == V_MAX) vs_lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hsd_q     <= 1'b0;
            vsd_q     <= 1'b0;
            h_hi_q    <= '0;
            h_lo_q    <= '0;
            v_hi_q    <= '0;
            v_lo_q    <= '0;
            hs_pol_q  <= 1'b0;
            hs_lock_q <= 1'b0;
            vs_pol_q  <= 1'b0;
            vs_lock_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            hsd_q     <= hs_in;
            vsd_q     <= vs_in;
            h_hi_q    <= h_hi_d;
            h_lo_q    <= h_lo_d;
            v_hi_q    <= v_hi_d;
            v_lo_q    <= v_lo_d;
            hs_pol_q  <= hs_pol_d;
            hs_lock_q <= hs_lock_d;
            vs_pol_q  <= vs_pol_d;
            vs_lock_q <= vs_lock_d;
            locked_q  <= hs_lock_q & vs_lock_q;
        end
    end

    // hs_act/vs_act are the syncs made active-high using the detected polarity.
    assign hs_act = hs_in ^ ~hs_pol_q;
    assign vs_act = vs_in ^ ~vs_pol_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_out_q <= 1'b1;
            vs_out_q <= 1'b1;
            cs_out_q <= 1'b1;
            hb_out_q <= 1'b0;
            vb_out_q <= 1'b0;
            r_out_q  <= '0;
            g_out_q  <= '0;
            b_out_q  <= '0;
        end else if (pixel_ena) begin
            hs_out_q <= ~hs_act;
            vs_out_q <= ~vs_act;
            cs_out_q <= csync_en ? ~(hs_act ^ vs_act) : ~hs_act;
            hb_out_q <= hb_in;
            vb_out_q <= vb_in;
            r_out_q  <= (hb_in | vb_in) ? 6'd0 : r_in;
            g_out_q  <= (hb_in | vb_in) ? 6'd0 : g_in;
            b_out_q  <= (hb_in | vb_in) ? 6'd0 : b_in;
        end
    end

    assign hs_out = hs_out_q;
    assign vs_out = vs_out_q;
    assign cs_out = cs_out_q;
    assign hb_out = hb_out_q;
    assign vb_out = vb_out_q;
    assign r_out  = r_out_q;
    assign g_out  = g_out_q;
    assign b_out  = b_out_q;
    assign hs_pol = hs_pol_q;
    assign vs_pol = vs_pol_q;
    assign locked = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_video_sync_normaliser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_sync_normaliser
//  Description : Directed stimulus with a queue-based output scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_sync_normaliser;

    localparam int LINE  = 40;
    localparam int HSW   = 5;
    localparam int HBW   = 10;
    localparam int FRAME = 12;
    localparam int VSW   = 2;
    localparam int VBW   = 3;

    logic       clk = 1'b0;
    logic       reset, pixel_ena, csync_en, hb_in, vb_in, hs_in, vs_in;
    logic [5:0] r_in, g_in, b_in;
    logic       hs_out, vs_out, cs_out, hb_out, vb_out, hs_pol, vs_pol, locked;
    logic [5:0] r_out, g_out, b_out;

    always #5 clk = ~clk;

    video_sync_normaliser #(.HCNT_W(12), .VCNT_W(11)) dut (
        .clk_sys(clk), .reset(reset), .pixel_ena(pixel_ena), .csync_en(csync_en),
        .hb_in(hb_in), .vb_in(vb_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_out(hs_out), .vs_out(vs_out), .cs_out(cs_out), .hb_out(hb_out), .vb_out(vb_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .locked(locked)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       cs;
        logic       hb;
        logic       vb;
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    bit   have_last = 0, chk = 0, count_en = 0, vs_enable = 1, csync = 0;
    bit   gen_hpol = 0, gen_vpol = 0, exp_hpol = 0, exp_vpol = 0;
    int   ena_div = 1, cyc = 0;
    int   checks = 0, errors = 0;
    int   vs_low_cnt = 0, serr_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; expected output is what the next rising edge must register.
    task automatic drive_cycle(input logic hs_a, input logic vs_a, input logic hb, input logic vb);
        logic hs_lvl, vs_lvl, ena, ha, va;
        logic [5:0] r, g, b;
        @(negedge clk);
        hs_lvl = gen_hpol ? hs_a : ~hs_a;
        vs_lvl = gen_vpol ? vs_a : ~vs_a;
        ena    = ((cyc % ena_div) == 0);
        cyc++;
        r = 6'h2A;
        g = 6'h15;
        b = 6'(cyc);
        hs_in = hs_lvl; vs_in = vs_lvl; hb_in = hb; vb_in = vb;
        r_in = r; g_in = g; b_in = b;
        pixel_ena = ena; csync_en = csync;
        if (ena) begin
            ha = exp_hpol ? hs_lvl : ~hs_lvl;
            va = exp_vpol ? vs_lvl : ~vs_lvl;
            last_exp.hs = ~ha;
            last_exp.vs = ~va;
            last_exp.cs = csync ? ~(ha ^ va) : ~ha;
            last_exp.hb = hb;
            last_exp.vb = vb;
            last_exp.r  = (hb | vb) ? 6'd0 : r;
            last_exp.g  = (hb | vb) ? 6'd0 : g;
            last_exp.b  = (hb | vb) ? 6'd0 : b;
            have_last   = 1;
        end
        if (!chk) have_last = 0;
        if (chk && have_last) q.push_back(last_exp);
        @(posedge clk);
        #1;
        if (count_en) begin
            if (!vs_out) vs_low_cnt++;
            if (cs_out && !vs_out) serr_cnt++;
        end
    endtask

    task automatic run_lines(input int first, input int n, input int chk_from);
        for (int l = first; l < first + n; l++) begin
            chk = (l >= chk_from);
            for (int c = 0; c < LINE; c++)
                drive_cycle(c < HSW, vs_enable && ((l % FRAME) < VSW), c < HBW,
                            vs_enable && ((l % FRAME) < VBW));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [25:0] act;
        act = {hs_out, vs_out, cs_out, hb_out, vb_out, r_out, g_out, b_out, hs_pol, vs_pol, locked};
        check(name, int'(act), int'({3'b111, 23'd0}));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        chk = 0; have_last = 0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one expected entry per rising edge that the driver queued for.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({hs_out, vs_out, cs_out, hb_out, vb_out, r_out, g_out, b_out} !== e) begin
                    errors++;
                    $display("FAIL out_pipe actual=%h expected=%h t=%0t",
                             {hs_out, vs_out, cs_out, hb_out, vb_out, r_out, g_out, b_out}, e, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pixel_ena = 1'b0; csync_en = 1'b0;
        hb_in = 1'b0; vb_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Active-low hsync, vsync held inactive
        gen_hpol = 0; gen_vpol = 0; exp_hpol = 0; exp_vpol = 0; vs_enable = 0;
        run_lines(0, 4, 2);
        check("t1_hs_pol", int'(hs_pol), 0);
        check("t1_locked", int'(locked), 1);

        // Active-high hsync and vsync, three frames from reset
        pulse_reset();
        gen_hpol = 1; gen_vpol = 1; exp_hpol = 1; exp_vpol = 1; vs_enable = 1;
        run_lines(0, 2 * FRAME, 2 * FRAME);
        vs_low_cnt = 0; count_en = 1;
        run_lines(2 * FRAME, FRAME, 0);
        count_en = 0;
        check("t2_vs_low_cycles", vs_low_cnt, VSW * LINE);
        check("t2_hs_pol", int'(hs_pol), 1);
        check("t2_vs_pol", int'(vs_pol), 1);
        check("t2_locked", int'(locked), 1);

        // Pixel enable every fourth clock; holding checked on idle cycles
        ena_div = 4;
        run_lines(3 * FRAME, FRAME, 0);
        ena_div = 1;

        // Composite sync: serration while vsync active
        csync = 1; serr_cnt = 0; count_en = 1;
        run_lines(4 * FRAME, FRAME, 0);
        count_en = 0; csync = 0;
        check("t4_serration_cycles", serr_cnt, VSW * HSW);

        // No hsync rising edges long enough for both counters to saturate
        chk = 1;
        for (int i = 0; i < 4200; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4200; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_locked_timeout", int'(locked), 0);
        check("t5_hs_pol_kept", int'(hs_pol), 1);
        check("t5_vs_pol_kept", int'(vs_pol), 1);
        run_lines(5, 2, 0);
        check("t5_relock", int'(locked), 1);

        // Reset in the middle of a line
        chk = 1;
        for (int c = 0; c < 20; c++) drive_cycle(c < HSW, 1'b0, c < HBW, 1'b0);
        @(negedge clk);
        chk = 0; have_last = 0; reset = 1'b1; pixel_ena = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_reset_midline");
        @(negedge clk);
        reset = 1'b0;
        run_lines(0, 3 * FRAME, 2 * FRAME);
        check("t6_relock", int'(locked), 1);
        check("t6_hs_pol", int'(hs_pol), 1);
        check("t6_vs_pol", int'(vs_pol), 1);

        chk = 0;
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
